// File: rtl/nf10_rr_input_arbiter.sv
// Five-to-one AXI4-Stream merge: per-input fall-through FIFOs, whole-packet round-robin grant.
// Optional NF10_INPUT_ARB_SRC_PORT_EN stamps a one-hot source-port code into tuser[23:16].
module nf10_rr_input_arbiter #(
  parameter int unsigned C_AXIS_DATA_WIDTH = 256,
  parameter int unsigned C_USER_WIDTH      = 128,
  parameter int unsigned NUM_QUEUES        = 5,
  parameter int unsigned FIFO_DEPTH_BITS   = 2
) (
  input  logic                           axi_aclk,
  input  logic                           axi_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_0,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_0,
  input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_0,
  input  logic                           s_axis_tvalid_0,
  output logic                           s_axis_tready_0,
  input  logic                           s_axis_tlast_0,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_1,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_1,
  input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_1,
  input  logic                           s_axis_tvalid_1,
  output logic                           s_axis_tready_1,
  input  logic                           s_axis_tlast_1,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_2,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_2,
  input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_2,
  input  logic                           s_axis_tvalid_2,
  output logic                           s_axis_tready_2,
  input  logic                           s_axis_tlast_2,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_3,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_3,
  input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_3,
  input  logic                           s_axis_tvalid_3,
  output logic                           s_axis_tready_3,
  input  logic                           s_axis_tlast_3,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_4,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_4,
  input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_4,
  input  logic                           s_axis_tvalid_4,
  output logic                           s_axis_tready_4,
  input  logic                           s_axis_tlast_4,
  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_USER_WIDTH-1:0]        m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast
);

  localparam int unsigned STRB_W = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned WORD_W = 1 + C_USER_WIDTH + STRB_W + C_AXIS_DATA_WIDTH;
  localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned CNT_W  = FIFO_DEPTH_BITS + 1;
  localparam int unsigned QW     = 3;

  typedef enum logic {IDLE, WR_PKT} state_t;

  logic [WORD_W-1:0]     in_word [NUM_QUEUES];
  logic [WORD_W-1:0]     head    [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] in_valid, in_rdy, wr_en, rd_en, empty, nearly_full;

  state_t                state_q;
  logic [QW-1:0]         cur_q, rr_q, sel_idx, scan_idx, nxt_rr;
  logic                  sel_found, accept_q, out_valid, xfer, head_last;
  logic [WORD_W-1:0]     head_sel;

  // Each FIFO word is {tlast, tuser, tstrb, tdata}
  assign in_word[0] = {s_axis_tlast_0, s_axis_tuser_0, s_axis_tstrb_0, s_axis_tdata_0};
  assign in_word[1] = {s_axis_tlast_1, s_axis_tuser_1, s_axis_tstrb_1, s_axis_tdata_1};
  assign in_word[2] = {s_axis_tlast_2, s_axis_tuser_2, s_axis_tstrb_2, s_axis_tdata_2};
  assign in_word[3] = {s_axis_tlast_3, s_axis_tuser_3, s_axis_tstrb_3, s_axis_tdata_3};
  assign in_word[4] = {s_axis_tlast_4, s_axis_tuser_4, s_axis_tstrb_4, s_axis_tdata_4};
  assign in_valid   = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2,
                       s_axis_tvalid_1, s_axis_tvalid_0};

  // accept_q holds every input off while in reset and for the edge it is released
  assign in_rdy = {NUM_QUEUES{accept_q}} & ~nearly_full;
  assign wr_en  = in_valid & in_rdy;
  assign s_axis_tready_0 = in_rdy[0];
  assign s_axis_tready_1 = in_rdy[1];
  assign s_axis_tready_2 = in_rdy[2];
  assign s_axis_tready_3 = in_rdy[3];
  assign s_axis_tready_4 = in_rdy[4];

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_fifo
    logic [WORD_W-1:0]          mem_q [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           cnt_q;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (wr_en[g]) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_BITS'(1);
        if (rd_en[g]) rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_BITS'(1);
        cnt_q <= cnt_q + CNT_W'(wr_en[g]) - CNT_W'(rd_en[g]);
      end
    end

    // Storage needs no reset: the occupancy count alone decides what is visible
    always_ff @(posedge axi_aclk) begin
      if (wr_en[g]) mem_q[wr_ptr_q] <= in_word[g];
    end

    assign head[g]        = mem_q[rd_ptr_q];
    assign empty[g]       = (cnt_q == '0);
    assign nearly_full[g] = (cnt_q >= CNT_W'(DEPTH - 1));
  end

  // First non-empty input scanning upward from rr_q
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_q;
    scan_idx  = rr_q;
    for (int unsigned k = 0; k < NUM_QUEUES; k++) begin
      scan_idx = QW'((32'(rr_q) + k) % NUM_QUEUES);
      if (!sel_found && !empty[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  assign head_sel  = head[cur_q];
  assign head_last = head_sel[WORD_W-1];
  assign out_valid = (state_q == WR_PKT) && !empty[cur_q];
  assign xfer      = out_valid && m_axis_tready;
  assign rd_en     = xfer ? (NUM_QUEUES'(1) << cur_q) : '0;
  assign nxt_rr    = (cur_q == QW'(NUM_QUEUES - 1)) ? '0 : cur_q + QW'(1);

`ifdef NF10_INPUT_ARB_SRC_PORT_EN
  logic [7:0] src_port_q;

  // Code latched at grant, i.e. the first-beat value, reused for every beat
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      src_port_q <= '0;
    end else if (state_q == IDLE && sel_found) begin
      src_port_q <= 8'h01 << {sel_idx, 1'b0};
    end
  end
`endif

  // Output fields come straight from the granted FIFO head; zero when not valid
  always_comb begin
    m_axis_tvalid = out_valid;
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    if (out_valid) begin
      {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = head_sel;
`ifdef NF10_INPUT_ARB_SRC_PORT_EN
      m_axis_tuser[23:16] = src_port_q;
`endif
    end
  end

  // Packet-granular arbiter: a grant is held until the tlast beat transfers
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      rr_q     <= '0;
      accept_q <= 1'b0;
    end else begin
      accept_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            cur_q   <= sel_idx;
            state_q <= WR_PKT;
          end
        end
        WR_PKT: begin
          if (xfer && head_last) begin
            rr_q    <= nxt_rr;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nf10_rr_input_arbiter.sv
// Randomized scoreboard bench for nf10_rr_input_arbiter with a queue-based reference model.
module tb_nf10_rr_input_arbiter;

  localparam int unsigned DW = 256;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned UW = 128;
  localparam int unsigned NQ = 5;

  typedef struct packed {
    logic          last;
    logic [UW-1:0] user;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata [NQ];
  logic [SW-1:0] s_tstrb [NQ];
  logic [UW-1:0] s_tuser [NQ];
  logic [NQ-1:0] s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tready, m_tlast;

  nf10_rr_input_arbiter dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .s_axis_tdata_0(s_tdata[0]), .s_axis_tstrb_0(s_tstrb[0]), .s_axis_tuser_0(s_tuser[0]),
    .s_axis_tvalid_0(s_tvalid[0]), .s_axis_tready_0(s_tready[0]), .s_axis_tlast_0(s_tlast[0]),
    .s_axis_tdata_1(s_tdata[1]), .s_axis_tstrb_1(s_tstrb[1]), .s_axis_tuser_1(s_tuser[1]),
    .s_axis_tvalid_1(s_tvalid[1]), .s_axis_tready_1(s_tready[1]), .s_axis_tlast_1(s_tlast[1]),
    .s_axis_tdata_2(s_tdata[2]), .s_axis_tstrb_2(s_tstrb[2]), .s_axis_tuser_2(s_tuser[2]),
    .s_axis_tvalid_2(s_tvalid[2]), .s_axis_tready_2(s_tready[2]), .s_axis_tlast_2(s_tlast[2]),
    .s_axis_tdata_3(s_tdata[3]), .s_axis_tstrb_3(s_tstrb[3]), .s_axis_tuser_3(s_tuser[3]),
    .s_axis_tvalid_3(s_tvalid[3]), .s_axis_tready_3(s_tready[3]), .s_axis_tlast_3(s_tlast[3]),
    .s_axis_tdata_4(s_tdata[4]), .s_axis_tstrb_4(s_tstrb[4]), .s_axis_tuser_4(s_tuser[4]),
    .s_axis_tvalid_4(s_tvalid[4]), .s_axis_tready_4(s_tready[4]), .s_axis_tlast_4(s_tlast[4]),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t exp_q [NQ][$];
  int    pkt_src[$];
  bit    m_busy = 1'b0;
  bit    m_rdy  = 1'b0;
  int    m_cur  = 0;
  int    m_rr   = 0;
  bit    rand_done = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < int'(DW / 32); i++) d = {d[DW-33:0], $urandom()};
    return d;
  endfunction

  function automatic int total_pending();
    int n;
    n = 0;
    for (int i = 0; i < int'(NQ); i++) n += exp_q[i].size();
    return n;
  endfunction

  // Reference model: per-input word queues, round-robin packet grants, one idle cycle between packets
  always @(negedge clk) begin
    logic [NQ-1:0] exp_rdy;
    word_t         w;
    logic [UW-1:0] eu;
    bit            found;
    int            j;
    if (!rst_n) begin
      chk("rst_tvalid", DW'(m_tvalid), '0);
      chk("rst_tready", DW'(s_tready), '0);
      chk("rst_out_ctl", DW'({m_tlast, m_tuser, m_tstrb}), '0);
      chk("rst_out_data", m_tdata, '0);
      for (int i = 0; i < int'(NQ); i++) exp_q[i].delete();
      m_busy = 1'b0;
      m_rr   = 0;
      m_rdy  = 1'b0;
    end else begin
      for (int i = 0; i < int'(NQ); i++) exp_rdy[i] = m_rdy && (exp_q[i].size() <= 2);
      chk("s_tready", DW'(s_tready), DW'(exp_rdy));
      if (!m_busy) begin
        chk("idle_tvalid", DW'(m_tvalid), '0);
        found = 1'b0;
        for (int k = 0; k < int'(NQ); k++) begin
          j = (m_rr + k) % int'(NQ);
          if (!found && exp_q[j].size() > 0) begin
            found = 1'b1;
            m_cur = j;
          end
        end
        if (found) begin
          m_busy = 1'b1;
          pkt_src.push_back(m_cur);
        end
      end else begin
        chk("pkt_tvalid", DW'(m_tvalid), DW'(exp_q[m_cur].size() > 0));
        if (m_tvalid && m_tready && exp_q[m_cur].size() > 0) begin
          w  = exp_q[m_cur].pop_front();
          eu = w.user;
`ifdef NF10_INPUT_ARB_SRC_PORT_EN
          eu[23:16] = 8'h01 << (2 * m_cur);
`endif
          chk("out_tdata", m_tdata, w.data);
          chk("out_tstrb", DW'(m_tstrb), DW'(w.strb));
          chk("out_tuser", DW'(m_tuser), DW'(eu));
          chk("out_tlast", DW'(m_tlast), DW'(w.last));
          if (w.last) begin
            m_busy = 1'b0;
            m_rr   = (m_cur + 1) % int'(NQ);
          end
        end
      end
      if (!m_tvalid) begin
        chk("zero_ctl", DW'({m_tlast, m_tuser, m_tstrb}), '0);
        chk("zero_data", m_tdata, '0);
      end
      for (int i = 0; i < int'(NQ); i++)
        if (s_tvalid[i] && exp_rdy[i])
          exp_q[i].push_back({s_tlast[i], s_tuser[i], s_tstrb[i], s_tdata[i]});
      m_rdy = 1'b1;
    end
  end

  // Drives one packet on input p; entered and left at posedge+1
  task automatic send_pkt(input int p, input int len, input int max_gap,
                          input int stall_at, input int stall_len, input logic [DW-1:0] base);
    bit         acc;
    int         guard;
    int         gap;
    logic [7:0] dst;
    dst = 8'($urandom_range(0, 255));
    for (int i = 0; i < len; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (i == stall_at) gap += stall_len;
      s_tvalid[p] = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      s_tvalid[p] = 1'b1;
      s_tdata[p]  = (base != '0) ? base + DW'(i) : rnd_data();
      s_tstrb[p]  = $urandom();
      s_tuser[p]  = {$urandom(), $urandom(), $urandom(), dst, 8'(p), 16'(len)};
      s_tlast[p]  = (i == len - 1);
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 1000) begin
        @(negedge clk);
        acc = s_tready[p];
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) begin
        chk("drv_timeout", '0, DW'(1));
        break;
      end
    end
    s_tvalid[p] = 1'b0;
    s_tlast[p]  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((total_pending() != 0 || m_busy || s_tvalid != '0) && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 5000) chk(name, DW'(total_pending()), '0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_order(input string name, input int exp_order[$]);
    chk({name, "_count"}, DW'(pkt_src.size()), DW'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < pkt_src.size(); i++)
      chk(name, DW'(pkt_src[i]), DW'(exp_order[i]));
  endtask

  task automatic port_traffic(input int p);
    repeat (6)
      send_pkt(p, int'($urandom_range(1, 6)), 2, ($urandom_range(0, 3) == 0) ? 1 : -1, 4, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    for (int i = 0; i < int'(NQ); i++) begin
      s_tdata[i] = '0;
      s_tstrb[i] = '0;
      s_tuser[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset then idle
    chk("t1_tready", DW'(s_tready), DW'(5'h1f));
    chk("t1_tvalid", DW'(m_tvalid), '0);
    chk("t1_data", m_tdata, '0);

    // One 3-word packet on input 2, then 1 and 3 together: rr_ptr=3 picks 3 first
    m_tready = 1'b1;
    pkt_src.delete();
    send_pkt(2, 3, 0, -1, 0, DW'(8'hA1));
    wait_drain("t2_drain");
    fork
      send_pkt(1, 1, 0, -1, 0, '0);
      send_pkt(3, 1, 0, -1, 0, '0);
    join
    wait_drain("t2b_drain");
    chk_order("t2_order", '{2, 3, 1});

    // Inputs 0, 1 and 4 pending at once after reset
    do_reset();
    pkt_src.delete();
    fork
      send_pkt(0, 2, 0, -1, 0, '0);
      send_pkt(1, 3, 0, -1, 0, '0);
      send_pkt(4, 2, 0, -1, 0, '0);
    join
    wait_drain("t3_drain");
    chk_order("t3_order", '{0, 1, 4});

    // Backpressure on a 6-word packet from input 3
    m_tready = 1'b0;
    pkt_src.delete();
    fork
      send_pkt(3, 6, 0, -1, 0, '0);
      begin
        repeat (10) @(posedge clk);
        #1 chk("t4_tready3", DW'(s_tready[3]), '0);
        m_tready = 1'b1;
      end
    join
    wait_drain("t4_drain");
    chk_order("t4_order", '{3});

    // Input 1 stalls mid-packet while input 0 has a full packet
    pkt_src.delete();
    fork
      send_pkt(1, 4, 0, 2, 8, '0);
      begin
        repeat (4) @(posedge clk);
        #1 send_pkt(0, 3, 0, -1, 0, '0);
      end
    join
    wait_drain("t5_drain");
    chk_order("t5_order", '{1, 0});

    // Asynchronous reset while a packet is in flight
    m_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_tvalid[0] = 1'b1;
      s_tdata[0]  = rnd_data();
      s_tstrb[0]  = $urandom();
      s_tuser[0]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      s_tlast[0]  = 1'b0;
      @(posedge clk); #1;
    end
    s_tvalid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("t6_pre_valid", DW'(m_tvalid), DW'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", DW'(m_tvalid), '0);
    chk("t6_async_data", m_tdata, '0);
    chk("t6_async_tready", DW'(s_tready), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b1;
    pkt_src.delete();
    send_pkt(0, 2, 0, -1, 0, '0);
    wait_drain("t6_drain");
    chk_order("t6_order", '{0});

    // Randomized concurrent traffic with random downstream backpressure
    pkt_src.delete();
    fork
      begin
        fork
          port_traffic(0);
          port_traffic(1);
          port_traffic(2);
          port_traffic(3);
          port_traffic(4);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 m_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_tready = 1'b1;
    wait_drain("rand_drain");
    chk("rand_pkts", DW'(pkt_src.size()), DW'(30));
    chk("end_empty", DW'(total_pending()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nf10_rr_input_arbiter.md
Name: nf10_rr_input_arbiter

Overview:
- Merges five NetFPGA-10G AXI4-Stream input ports into one output stream. Feeds the datapath ahead of the output-queue block, so it is the many-to-one mirror of the queue demux.
- Each input has a small fall-through FIFO. A round-robin arbiter grants one whole packet at a time, so packets are never interleaved on the output.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width; tstrb width is C_AXIS_DATA_WIDTH/8.
- C_USER_WIDTH, 128, tuser width; must be at least 32.
- NUM_QUEUES, 5, number of inputs; fixed at 5 by the port list.
- FIFO_DEPTH_BITS, 2, log2 of the per-input FIFO depth, giving 4 words.

Ports:
- axi_aclk  in  1  the single clock.
- axi_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata_i  in  C_AXIS_DATA_WIDTH  input i data, for i=0..4 (five ports, one per i, same for every s_axis_* line below).
- s_axis_tstrb_i  in  C_AXIS_DATA_WIDTH/8  input i byte strobes.
- s_axis_tuser_i  in  C_USER_WIDTH  input i metadata; [15:0] is length, [23:16] is src_port, [31:24] is dst_port.
- s_axis_tvalid_i  in  1  input i valid.
- s_axis_tready_i  out  1  input i ready.
- s_axis_tlast_i  in  1  input i end of packet.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  merged output data.
- m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  merged output byte strobes.
- m_axis_tuser  out  C_USER_WIDTH  merged output metadata.
- m_axis_tvalid  out  1  merged output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  merged output end of packet.

Behaviour:
- Reset:
  - axi_resetn low asynchronously forces state to IDLE, cur_queue to 0 and rr_ptr to 0, and flushes all FIFOs.
  - During reset, m_axis_tvalid=0 and s_axis_tready_i=0.
  - m_axis_tdata, tstrb, tuser and tlast are 0 whenever m_axis_tvalid=0, including during reset.
  - Reset deassertion is used directly; one cycle after deassertion all s_axis_tready_i are 1.
  - Reset mid-packet discards all buffered words; no partial packet is emitted afterwards.
- Input side:
  - Each FIFO stores {tlast, tuser, tstrb, tdata} per word.
  - s_axis_tready_i = ~nearly_full_i, where nearly_full_i means at most 1 free entry.
  - A word is written when s_axis_tvalid_i & s_axis_tready_i.
  - Inputs accept words independently of arbitration.
- Arbiter state machine (IDLE, WR_PKT):
  - IDLE:
    - m_axis_tvalid=0.
    - If any FIFO is non-empty, select the first non-empty index scanning rr_ptr, rr_ptr+1, ... modulo 5.
    - Latch it into cur_queue and go to WR_PKT on the next edge.
    - If all FIFOs are empty, stay in IDLE.
  - WR_PKT:
    - m_axis_tvalid = ~empty[cur_queue]; output fields come from that FIFO's head (fall-through, zero read latency).
    - rd_en[cur_queue] = m_axis_tvalid & m_axis_tready; no other FIFO is read.
    - On a transferred beat with tlast=1: go to IDLE and set rr_ptr = cur_queue+1, wrapping 4 to 0.
    - If the granted FIFO runs empty mid-packet, hold WR_PKT with tvalid=0 and wait; never switch input mid-packet.
- Latency:
  - Empty arbiter with a word arriving at edge N: the word is visible at the FIFO head after edge N. IDLE grants at edge N+1, so m_axis_tvalid rises in the cycle after edge N+1.
  - There is one mandatory IDLE bubble cycle between consecutive packets.
- AXI rule: once m_axis_tvalid is asserted, the output holds stable until m_axis_tready. Guaranteed because the FIFO head changes only on rd_en.
- Fairness: an input that always has traffic is granted at least once every 5 packets.
- Simultaneous write and read on the same FIFO in one cycle are both honoured.
- tuser passes through unchanged per word unless the optional feature below is enabled.

Optional Feature:
- Macro: NF10_INPUT_ARB_SRC_PORT_EN.
- Defined: on the first beat of each packet, m_axis_tuser[23:16] is overwritten with 8'h01<<(2*cur_queue). That gives 01, 04, 10 and 40 for inputs 0-3; input 4 gives 8'h00, since bit 8 is out of range.
- Defined: on every beat, m_axis_tuser[23:16] is overwritten with the first-beat value; the other tuser bits are unchanged.
- Undefined: tuser is passed through unchanged and there is no first-beat tracking logic.

Test Plan:
1. Reset then idle, no stimulus -> m_axis_tvalid=0 and all outputs 0; all s_axis_tready_i=1 one cycle after deassertion.
2. One 3-word packet on input 2 with tdata 0xA1, 0xA2, 0xA3 and m_axis_tready=1 -> output words are 0xA1, 0xA2, 0xA3 with tlast on the third only; afterwards rr_ptr=3.
3. Packets pending on inputs 0, 1 and 4 simultaneously, rr_ptr=0 -> output packet order is 0, 1, 4, with one tvalid=0 bubble between packets.
4. m_axis_tready=0 for 10 cycles during a 6-word packet from input 3 -> s_axis_tready_3 drops after 3 words are buffered; all 6 words are delivered in order with no loss once tready=1.
5. Input 1 stalls mid-packet while input 0 has a full packet ready -> the output stays on input 1 with tvalid=0 until it resumes; input 0's packet follows input 1's tlast.
6. axi_resetn asserted while word 2 of 4 is in flight -> tvalid drops immediately (asynchronously); after release, a new packet on input 0 is output cleanly with no stale words.
